v_lsu_ctrl: RTL and testbench

Vector load/store sequencer that sits directly upstream of v_mem. It accepts one vector memory op from the vector execute stage over a valid/ready handshake. It forms the effective address and drives v_mem's request, width, len, vlx/vsx and sign-flag inputs for the whole op. For loads it waits a fixed VRAM read latency, captures the v_mem result and writes it to the vector register file. One op is in flight at a time.

---
 rtl/v_lsu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_v_lsu_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v_lsu_ctrl.sv
// v_lsu_ctrl: one-op-at-a-time vector load/store sequencer driving v_mem and the vector register file.
// Optional macro V_LSU_ALIGN_CHK_EN rejects misaligned addresses and width codes above 3 at accept.
module v_lsu_ctrl #(
    parameter int VLEN    = 512,
    parameter int ADDR_W  = 64,
    parameter int RD_LAT  = 1,
    parameter int VREG_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid_i,
    output logic               op_ready_o,
    input  logic               op_is_load_i,
    input  logic               op_is_store_i,
    input  logic               op_is_vlx_i,
    input  logic               op_is_vsx_i,
    input  logic               op_signed_i,
    input  logic [2:0]         op_width_i,
    input  logic [2:0]         op_len_i,
    input  logic [ADDR_W-1:0]  op_base_i,
    input  logic [ADDR_W-1:0]  op_offset_i,
    input  logic [VREG_AW-1:0] op_vd_i,
    input  logic [VLEN-1:0]    op_vs3_data_i,
    output logic               vmem_ren_o,
    output logic               vmem_wen_o,
    output logic [ADDR_W-1:0]  vmem_addr_o,
    output logic [VLEN-1:0]    vmem_din_o,
    output logic [2:0]         vmem_width_o,
    output logic [2:0]         vmem_len_o,
    output logic               vmem_is_vlx_o,
    output logic               vmem_is_vsx_o,
    input  logic [VLEN-1:0]    vmem_dout_i,
    output logic               vrf_wen_o,
    output logic [VREG_AW-1:0] vrf_waddr_o,
    output logic [VLEN-1:0]    vrf_wdata_o,
    output logic               done_o,
    output logic               err_o
);
    // state | meaning
    // IDLE  | ready, waiting for an op
    // REQ   | single-cycle read or write strobe to v_mem
    // WAIT  | counting down the VRAM read latency, capture on zero
    // WB    | register-file write pulse
    // FIN   | done pulse (with err for rejected ops)
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_WB   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

    state_t             state;
    logic [2:0]         cnt;
    logic               is_load_q;
    logic [VREG_AW-1:0] vd_q;
    logic [ADDR_W-1:0]  addr_sum;
    logic               kind_bad;
    logic               align_bad;
    logic [VLEN-1:0]    accept_din;

    assign addr_sum = op_base_i + op_offset_i;
    assign kind_bad = (op_is_load_i == op_is_store_i);

    always_comb begin
        accept_din = '0;
        if (op_is_store_i)
            accept_din = op_vs3_data_i;
        else
            accept_din[0] = op_is_vlx_i & op_signed_i;
    end

`ifdef V_LSU_ALIGN_CHK_EN
    logic       narrow;
    logic [2:0] lsb_mask;
    always_comb begin
        narrow   = (op_is_load_i & op_is_vlx_i) | (op_is_store_i & op_is_vsx_i);
        lsb_mask = 3'b111;
        if (narrow) begin
            case (op_width_i)
                3'd0:    lsb_mask = 3'b000;
                3'd1:    lsb_mask = 3'b001;
                3'd2:    lsb_mask = 3'b011;
                default: lsb_mask = 3'b111;
            endcase
        end
        align_bad = (op_width_i > 3'd3) | (|(addr_sum[2:0] & lsb_mask));
    end
`else
    assign align_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            is_load_q     <= 1'b0;
            vd_q          <= '0;
            op_ready_o    <= 1'b0;
            vmem_ren_o    <= 1'b0;
            vmem_wen_o    <= 1'b0;
            vmem_addr_o   <= '0;
            vmem_din_o    <= '0;
            vmem_width_o  <= '0;
            vmem_len_o    <= '0;
            vmem_is_vlx_o <= 1'b0;
            vmem_is_vsx_o <= 1'b0;
            vrf_wen_o     <= 1'b0;
            vrf_waddr_o   <= '0;
            vrf_wdata_o   <= '0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            vmem_ren_o <= 1'b0;
            vmem_wen_o <= 1'b0;
            vrf_wen_o  <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    op_ready_o <= 1'b1;
                    if (op_valid_i && op_ready_o) begin
                        op_ready_o <= 1'b0;
                        is_load_q  <= op_is_load_i;
                        vd_q       <= op_vd_i;
                        if (kind_bad || align_bad) begin
                            state  <= S_FIN;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
                            // v_mem is combinational on these; they stay put until FIN
                            state         <= S_REQ;
                            vmem_ren_o    <= op_is_load_i;
                            vmem_wen_o    <= op_is_store_i;
                            vmem_addr_o   <= addr_sum;
                            vmem_din_o    <= accept_din;
                            vmem_width_o  <= op_width_i;
                            vmem_len_o    <= op_len_i;
                            vmem_is_vlx_o <= op_is_vlx_i & op_is_load_i;
                            vmem_is_vsx_o <= op_is_vsx_i & op_is_store_i;
                        end
                    end
                end
                S_REQ: begin
                    if (is_load_q) begin
                        state <= S_WAIT;
                        cnt   <= CNT_INIT;
                    end else begin
                        state  <= S_FIN;
                        done_o <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        vrf_wdata_o <= vmem_dout_i;
                        vrf_wen_o   <= 1'b1;
                        vrf_waddr_o <= vd_q;
                        state       <= S_WB;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_WB: begin
                    vrf_waddr_o <= '0;
                    done_o      <= 1'b1;
                    state       <= S_FIN;
                end
                S_FIN: begin
                    state         <= S_IDLE;
                    op_ready_o    <= 1'b1;
                    is_load_q     <= 1'b0;
                    vd_q          <= '0;
                    vmem_addr_o   <= '0;
                    vmem_din_o    <= '0;
                    vmem_width_o  <= '0;
                    vmem_len_o    <= '0;
                    vmem_is_vlx_o <= 1'b0;
                    vmem_is_vsx_o <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_v_lsu_ctrl.sv
// Bench for v_lsu_ctrl: transaction-level schedule model checked every cycle, directed and random ops.
module tb_v_lsu_ctrl;
    localparam int VLEN    = 512;
    localparam int ADDR_W  = 64;
    localparam int RD_LAT  = 2;
    localparam int VREG_AW = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               op_valid_i = 1'b0;
    logic               op_ready_o;
    logic               op_is_load_i = 1'b0;
    logic               op_is_store_i = 1'b0;
    logic               op_is_vlx_i = 1'b0;
    logic               op_is_vsx_i = 1'b0;
    logic               op_signed_i = 1'b0;
    logic [2:0]         op_width_i = '0;
    logic [2:0]         op_len_i = '0;
    logic [ADDR_W-1:0]  op_base_i = '0;
    logic [ADDR_W-1:0]  op_offset_i = '0;
    logic [VREG_AW-1:0] op_vd_i = '0;
    logic [VLEN-1:0]    op_vs3_data_i = '0;
    logic               vmem_ren_o;
    logic               vmem_wen_o;
    logic [ADDR_W-1:0]  vmem_addr_o;
    logic [VLEN-1:0]    vmem_din_o;
    logic [2:0]         vmem_width_o;
    logic [2:0]         vmem_len_o;
    logic               vmem_is_vlx_o;
    logic               vmem_is_vsx_o;
    logic [VLEN-1:0]    vmem_dout_i = '0;
    logic               vrf_wen_o;
    logic [VREG_AW-1:0] vrf_waddr_o;
    logic [VLEN-1:0]    vrf_wdata_o;
    logic               done_o;
    logic               err_o;

    v_lsu_ctrl #(.VLEN(VLEN), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .VREG_AW(VREG_AW)) dut (
        .clk(clk), .rst(rst),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_is_load_i(op_is_load_i), .op_is_store_i(op_is_store_i),
        .op_is_vlx_i(op_is_vlx_i), .op_is_vsx_i(op_is_vsx_i), .op_signed_i(op_signed_i),
        .op_width_i(op_width_i), .op_len_i(op_len_i),
        .op_base_i(op_base_i), .op_offset_i(op_offset_i),
        .op_vd_i(op_vd_i), .op_vs3_data_i(op_vs3_data_i),
        .vmem_ren_o(vmem_ren_o), .vmem_wen_o(vmem_wen_o),
        .vmem_addr_o(vmem_addr_o), .vmem_din_o(vmem_din_o),
        .vmem_width_o(vmem_width_o), .vmem_len_o(vmem_len_o),
        .vmem_is_vlx_o(vmem_is_vlx_o), .vmem_is_vsx_o(vmem_is_vsx_o),
        .vmem_dout_i(vmem_dout_i),
        .vrf_wen_o(vrf_wen_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [VLEN-1:0] rand_vlen();
        logic [VLEN-1:0] v;
        v = '0;
        for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // load-result bus: random every cycle unless a directed test pins it
    logic            dout_fixed = 1'b0;
    logic [VLEN-1:0] dout_const = '0;
    always @(posedge clk) begin
        #1;
        vmem_dout_i = dout_fixed ? dout_const : rand_vlen();
    end

    // Model: an accepted op occupies cycles rel=1..lat after the accept cycle.
    // Legal store lat=2, legal load lat=RD_LAT+3, rejected op lat=1.
    bit                 m_busy = 1'b0;
    bit                 m_ready = 1'b0;
    int                 m_rel = 0;
    int                 m_lat = 0;
    bit                 m_err = 1'b0;
    bit                 m_load = 1'b0;
    logic [ADDR_W-1:0]  m_addr = '0;
    logic [VLEN-1:0]    m_din = '0;
    logic [2:0]         m_width = '0;
    logic [2:0]         m_len = '0;
    bit                 m_vlx = 1'b0;
    bit                 m_vsx = 1'b0;
    logic [VREG_AW-1:0] m_vd = '0;
    logic [VLEN-1:0]    m_wdata = '0;

    logic               e_drive, e_ren, e_wen, e_vwen, e_done, e_err;
    logic [VREG_AW-1:0] e_waddr;

    always @(negedge clk) begin
        e_drive = 1'b0; e_ren = 1'b0; e_wen = 1'b0; e_vwen = 1'b0;
        e_done = 1'b0; e_err = 1'b0; e_waddr = '0;
        if (!rst) begin
            m_busy = 1'b0;
            m_ready = 1'b0;
            m_wdata = '0;
        end else if (m_busy) begin
            e_drive = !m_err;
            e_ren   = !m_err && m_load && (m_rel == 1);
            e_wen   = !m_err && !m_load && (m_rel == 1);
            e_vwen  = !m_err && m_load && (m_rel == RD_LAT + 2);
            e_waddr = e_vwen ? m_vd : '0;
            e_done  = (m_rel == m_lat);
            e_err   = m_err && e_done;
        end
        chk1("op_ready", op_ready_o, m_ready);
        chk1("vmem_ren", vmem_ren_o, e_ren);
        chk1("vmem_wen", vmem_wen_o, e_wen);
        chk64("vmem_addr", vmem_addr_o, e_drive ? m_addr : 64'd0);
        chkw("vmem_din", vmem_din_o, e_drive ? m_din : '0);
        chk64("vmem_width", 64'(vmem_width_o), e_drive ? 64'(m_width) : 64'd0);
        chk64("vmem_len", 64'(vmem_len_o), e_drive ? 64'(m_len) : 64'd0);
        chk1("vmem_is_vlx", vmem_is_vlx_o, e_drive & m_vlx);
        chk1("vmem_is_vsx", vmem_is_vsx_o, e_drive & m_vsx);
        chk1("vrf_wen", vrf_wen_o, e_vwen);
        chk64("vrf_waddr", 64'(vrf_waddr_o), 64'(e_waddr));
        chkw("vrf_wdata", vrf_wdata_o, m_wdata);
        chk1("done", done_o, e_done);
        chk1("err", err_o, e_err);
        if (rst) begin
            if (m_busy) begin
                if (!m_err && m_load && m_rel == RD_LAT + 1) m_wdata = vmem_dout_i;
                if (m_rel == m_lat) m_busy = 1'b0;
                else m_rel++;
            end else if (m_ready && op_valid_i) begin
                m_busy  = 1'b1;
                m_rel   = 1;
                m_load  = op_is_load_i;
                m_err   = (op_is_load_i == op_is_store_i);
                m_addr  = op_base_i + op_offset_i;
                m_width = op_width_i;
                m_len   = op_len_i;
                m_vd    = op_vd_i;
                m_vlx   = op_is_load_i & op_is_vlx_i;
                m_vsx   = op_is_store_i & op_is_vsx_i;
                if (op_is_store_i) m_din = op_vs3_data_i;
                else m_din = VLEN'(op_is_vlx_i & op_signed_i);
`ifdef V_LSU_ALIGN_CHK_EN
                begin
                    longint unsigned sz;
                    sz = (m_vlx || m_vsx) ? (longint'(1) << op_width_i) : 64'd8;
                    if (op_width_i > 3'd3 || (m_addr % sz) != 0) m_err = 1'b1;
                end
`endif
                m_lat = m_err ? 1 : (m_load ? RD_LAT + 3 : 2);
            end
            m_ready = !m_busy;
        end
    end

    task automatic set_op(input bit ld, input bit st, input bit vlx, input bit vsx, input bit sgn,
                          input logic [2:0] w, input logic [2:0] len,
                          input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] off,
                          input logic [VREG_AW-1:0] vd, input logic [VLEN-1:0] data);
        op_is_load_i = ld; op_is_store_i = st; op_is_vlx_i = vlx; op_is_vsx_i = vsx;
        op_signed_i = sgn; op_width_i = w; op_len_i = len; op_base_i = base;
        op_offset_i = off; op_vd_i = vd; op_vs3_data_i = data;
    endtask

    // raise valid, wait for ready, return at posedge+1 of the first op cycle
    task automatic issue();
        int n;
        n = 0;
        op_valid_i = 1'b1;
        @(negedge clk);
        while (!op_ready_o && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (n >= 40) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=no_ready required=ready t=%0t", $time);
        end
        @(posedge clk); #1;
        op_valid_i = 1'b0;
    endtask

    logic [VLEN-1:0] lanes;
    int              gap;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_ready", op_ready_o, 1'b0);
        chk64("rst_addr", vmem_addr_o, 64'd0);
        chk1("rst_done", done_o, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk1("ready_first_cycle_low", op_ready_o, 1'b0);
        @(negedge clk);
        chk1("ready_after_reset", op_ready_o, 1'b1);

        // VSX store
        lanes = '0;
        lanes[63:0]    = 64'h1111_1111_1111_1111;
        lanes[127:64]  = 64'h2222_2222_2222_2222;
        lanes[191:128] = 64'h3333_3333_3333_3333;
        lanes[255:192] = 64'h4444_4444_4444_4444;
        @(posedge clk); #1;
        set_op(0, 1, 0, 1, 0, 3'd1, 3'd3, 64'h8100_0000, 64'h10, 5'd0, lanes);
        issue();
        @(negedge clk);
        chk1("st_wen", vmem_wen_o, 1'b1);
        chk64("st_addr", vmem_addr_o, 64'h8100_0010);
        chk1("st_is_vsx", vmem_is_vsx_o, 1'b1);
        chk64("st_lane3", vmem_din_o[255:192], 64'h4444_4444_4444_4444);
        @(negedge clk);
        chk1("st_done", done_o, 1'b1);
        chk1("st_wen_once", vmem_wen_o, 1'b0);

        // signed VLX load
        dout_fixed = 1'b1;
        dout_const = {16{32'hCAFE_0042}};
        @(posedge clk); #1;
        set_op(1, 0, 1, 0, 1, 3'd0, 3'd7, 64'h2000, 64'h40, 5'd5, rand_vlen());
        issue();
        @(negedge clk);
        chk1("ld_ren", vmem_ren_o, 1'b1);
        chkw("ld_din_sign", vmem_din_o, VLEN'(1));
        @(negedge clk);
        @(negedge clk);
        chk64("ld_len_at_capture", 64'(vmem_len_o), 64'd7);
        chk1("ld_vlx_at_capture", vmem_is_vlx_o, 1'b1);
        @(negedge clk);
        chk1("ld_vrf_wen", vrf_wen_o, 1'b1);
        chk64("ld_waddr", 64'(vrf_waddr_o), 64'd5);
        chkw("ld_wdata", vrf_wdata_o, {16{32'hCAFE_0042}});
        @(negedge clk);
        chk1("ld_done_5", done_o, 1'b1);
        @(posedge clk); #1;
        dout_fixed = 1'b0;

        // back-to-back load then store with valid held
        set_op(1, 0, 0, 0, 0, 3'd3, 3'd0, 64'h100, 64'h8, 5'd9, '0);
        op_valid_i = 1'b1;
        gap = 0;
        @(negedge clk);
        while (!op_ready_o && gap < 40) begin gap++; @(negedge clk); end
        @(posedge clk); #1;
        set_op(0, 1, 0, 0, 0, 3'd3, 3'd1, 64'h3000, 64'h20, 5'd0, rand_vlen());
        gap = 0;
        @(negedge clk);
        while (!op_ready_o && gap < 40) begin gap++; @(negedge clk); end
        chk64("b2b_ready_low_cycles", 64'(gap), 64'(RD_LAT + 3));
        @(posedge clk); #1;
        op_valid_i = 1'b0;
        @(negedge clk);
        chk64("b2b_second_addr", vmem_addr_o, 64'h3020);

        // address wrap
        repeat (2) @(posedge clk); #1;
        set_op(0, 1, 0, 0, 0, 3'd3, 3'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 5'd0, rand_vlen());
        issue();
        @(negedge clk);
        chk64("wrap_addr", vmem_addr_o, 64'h8);

        // reset in WAIT
        repeat (2) @(posedge clk); #1;
        set_op(1, 0, 0, 0, 0, 3'd3, 3'd2, 64'h400, 64'h0, 5'd3, '0);
        issue();
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk64("midrst_addr", vmem_addr_o, 64'd0);
        chk1("midrst_ready", op_ready_o, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk1("midrst_ready_after", op_ready_o, 1'b1);
        chk1("midrst_no_vrf", vrf_wen_o, 1'b0);

        // illegal kind
        @(posedge clk); #1;
        set_op(1, 1, 0, 0, 0, 3'd3, 3'd0, 64'h0, 64'h0, 5'd1, '0);
        issue();
        @(negedge clk);
        chk1("illegal_done", done_o, 1'b1);
        chk1("illegal_err", err_o, 1'b1);
        chk1("illegal_no_ren", vmem_ren_o, 1'b0);
`ifdef V_LSU_ALIGN_CHK_EN
        @(posedge clk); #1;
        set_op(0, 1, 0, 1, 0, 3'd2, 3'd0, 64'h1000, 64'h2, 5'd0, rand_vlen());
        issue();
        @(negedge clk);
        chk1("misalign_err", err_o, 1'b1);
        chk1("misalign_no_wen", vmem_wen_o, 1'b0);
`endif

        // random phase, with one reset pulse part-way
        for (int i = 0; i < 400; i++) begin
            int kind;
            @(posedge clk); #1;
            if (i == 200) rst = 1'b0;
            if (i == 202) rst = 1'b1;
            kind = int'($urandom_range(0, 9));
            op_is_load_i  = (kind == 0) || (kind >= 2 && kind < 6);
            op_is_store_i = (kind == 0) || (kind >= 6);
            op_is_vlx_i   = 1'($urandom);
            op_is_vsx_i   = 1'($urandom);
            op_signed_i   = 1'($urandom);
            op_width_i    = 3'($urandom);
            op_len_i      = 3'($urandom);
            op_base_i     = {$urandom, $urandom};
            op_offset_i   = {$urandom, $urandom};
            op_vd_i       = 5'($urandom);
            op_vs3_data_i = rand_vlen();
            op_valid_i    = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        op_valid_i = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
